// File: rtl/shift_rows_stream_if.sv
// rtl/shift_rows_stream_if.sv - block stream interface for shift_rows_stream
//
// Purpose: carries one Rijndael state block plus its mode bit and sideband
//          tag across a valid/ready handshake.
// Signals:
//   valid  producer has a block present
//   ready  consumer accepts on valid && ready at a clock edge
//   inv    1 = InvShiftRows, 0 = ShiftRows
//   tag    sideband tag, TAG_W bits
//   data   state, 32*NB bits, column-major, MSB first
// Modports:
//   master  drives valid/inv/tag/data, samples ready
//   slave   samples valid/inv/tag/data, drives ready
interface shift_rows_stream_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) ();
  logic              valid;
  logic              ready;
  logic              inv;
  logic [TAG_W-1:0]  tag;
  logic [32*NB-1:0]  data;

  modport master (
    output valid,
    output inv,
    output tag,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  inv,
    input  tag,
    input  data,
    output ready
  );
endinterface

// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - pipelined ShiftRows/InvShiftRows engine with 2-entry output buffer
//
// Purpose: permutes the bytes of a Rijndael state block (Nb = 4, 6 or 8)
//          forward or inverse, per block, and queues the result in a
//          2-entry FIFO so it can sit between two pipeline stages under
//          back-pressure.
// Ports:
//   clk    single clock, rising edge
//   rst    asynchronous active-high reset
//   in_s   upstream block stream (slave side: valid/inv/tag/data in, ready out)
//   out_m  downstream block stream (master side: valid/inv/tag/data out, ready in)
//   busy   1 while at least one block is held in the buffer
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_rows_stream_if.slave  in_s,
  shift_rows_stream_if.master out_m,
  output logic                busy
);

  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  // Combinational permutation of the incoming block
  logic [W-1:0] w_fwd;
  logic [W-1:0] w_inv;
  logic [W-1:0] w_perm;

  // Buffer control
  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // 2-entry storage, pointers and occupancy
  logic [1:0][W-1:0]     r_mem_data;
  logic [1:0]            r_mem_inv;
  logic [1:0][TAG_W-1:0] r_mem_tag;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  // Byte (r,c) sits at bit offset 8*(4c+r) from the MSB. Every source index
  // is a constant, so each output byte is a fixed wire plus a 2:1 mode mux.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row offsets: {0,1,2,3} for Nb=4/6, {0,1,3,4} for Nb=8.
      localparam int OFF = (r == 0) ? 0 :
                           (r == 1) ? 1 :
                           (r == 2) ? ((NB == 8) ? 3 : 2) :
                                      ((NB == 8) ? 4 : 3);
      localparam int SRC_F = (c + OFF) % NB;
      localparam int SRC_I = (c - OFF + NB) % NB;

      assign w_fwd[W-1-8*(4*c+r) -: 8] = in_s.data[W-1-8*(4*SRC_F+r) -: 8];
      assign w_inv[W-1-8*(4*c+r) -: 8] = in_s.data[W-1-8*(4*SRC_I+r) -: 8];
    end
  end

  assign w_perm = in_s.inv ? w_inv : w_fwd;

  // Ready depends on occupancy alone, never on out_m.ready, so no
  // combinational path runs from the downstream ready back upstream.
  assign w_in_ready  = (r_count < 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = in_s.valid & w_in_ready;
  assign w_pop       = w_out_valid & out_m.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_data <= '0;
      r_mem_inv  <= '0;
      r_mem_tag  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      // in_s.data is only sampled on an accepted push, so X on an idle
      // input never reaches the storage.
      if (w_push) begin
        r_mem_data[r_wptr] <= w_perm;
        r_mem_inv[r_wptr]  <= in_s.inv;
        r_mem_tag[r_wptr]  <= in_s.tag;
        r_wptr             <= ~r_wptr;
      end

      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head entry drives the outputs directly; storage resets to zero so
  // the outputs read zero after reset.
  assign in_s.ready  = w_in_ready;
  assign out_m.valid = w_out_valid;
  assign out_m.data  = r_mem_data[r_rptr];
  assign out_m.inv   = r_mem_inv[r_rptr];
  assign out_m.tag   = r_mem_tag[r_rptr];
  assign busy        = w_out_valid;

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - self-checking bench for shift_rows_stream
//
// Purpose: exercises Nb=4 (main instance), Nb=6 and Nb=8 instances of
//          shift_rows_stream with known vectors, a reference permutation
//          and a scoreboard queue.
// Ports: none (top-level bench).
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_rows_stream_if #(.NB(4), .TAG_W(4)) in4 ();
  shift_rows_stream_if #(.NB(4), .TAG_W(4)) out4 ();
  shift_rows_stream_if #(.NB(6), .TAG_W(4)) in6 ();
  shift_rows_stream_if #(.NB(6), .TAG_W(4)) out6 ();
  shift_rows_stream_if #(.NB(8), .TAG_W(4)) in8 ();
  shift_rows_stream_if #(.NB(8), .TAG_W(4)) out8 ();
  logic busy4, busy6, busy8;

  shift_rows_stream #(.NB(4), .TAG_W(4)) dut4 (.clk(clk), .rst(rst), .in_s(in4), .out_m(out4), .busy(busy4));
  shift_rows_stream #(.NB(6), .TAG_W(4)) dut6 (.clk(clk), .rst(rst), .in_s(in6), .out_m(out6), .busy(busy6));
  shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst(rst), .in_s(in8), .out_m(out8), .busy(busy8));

  int n_checks = 0;
  int n_errors = 0;
  logic [132:0] sb[$];

  // Reference permutation on a right-aligned block of 32*nb bits.
  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input bit inv);
    logic [255:0] o;
    int off, src, w;
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++) begin
      off = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? ((nb == 8) ? 3 : 2) : ((nb == 8) ? 4 : 3);
      for (int c = 0; c < nb; c++) begin
        src = inv ? ((c - off + nb) % nb) : ((c + off) % nb);
        o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [132:0] exp4(input logic [127:0] d, input logic inv, input logic [3:0] tag);
    logic [255:0] p;
    p = ref_perm(4, {128'b0, d}, inv);
    return {inv, tag, p[127:0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in4.valid = 0; in4.inv = 0; in4.tag = '0; in4.data = 'x; out4.ready = 1;
    in6.valid = 0; in6.inv = 0; in6.tag = '0; in6.data = 'x; out6.ready = 1;
    in8.valid = 0; in8.inv = 0; in8.tag = '0; in8.data = 'x; out8.ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out4.valid, busy4, in4.ready, out4.inv, out4.tag} !== 8'b0010_0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got v=%b busy=%b rdy=%b inv=%b tag=%h want v=0 busy=0 rdy=1 inv=0 tag=0",
               out4.valid, busy4, in4.ready, out4.inv, out4.tag);
    end
    n_checks++;
    if (out4.data !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h want 0", out4.data);
    end
    n_checks++;
    if ({out6.valid, out8.valid, in6.ready, in8.ready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL reset_nb68: got v6=%b v8=%b r6=%b r8=%b want 0 0 1 1", out6.valid, out8.valid, in6.ready, in8.ready);
    end
  endtask

  task automatic test_vector(input logic [127:0] din, input logic inv, input logic [3:0] tag,
                             input logic [127:0] dexp, input string name);
    @(posedge clk); #1;
    in4.valid = 1; in4.data = din; in4.inv = inv; in4.tag = tag; out4.ready = 1;
    @(posedge clk); #1;
    in4.valid = 0; in4.data = 'x;
    @(negedge clk);
    n_checks++;
    if ({out4.valid, out4.inv, out4.tag, out4.data} !== {1'b1, inv, tag, dexp}) begin
      n_errors++;
      $display("FAIL %s: got v=%b inv=%b tag=%h data=%h want v=1 inv=%b tag=%h data=%h",
               name, out4.valid, out4.inv, out4.tag, out4.data, inv, tag, dexp);
    end
    @(negedge clk);
    n_checks++;
    if (out4.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_drain: got out_valid=%b want 0", name, out4.valid);
    end
  endtask

  task automatic test_mixed_pair();
    logic [127:0] a, b;
    logic [132:0] e;
    a = rand128();
    b = rand128();
    @(posedge clk); #1;
    in4.valid = 1; in4.data = a; in4.inv = 0; in4.tag = 4'h5; out4.ready = 1;
    sb.push_back(exp4(a, 1'b0, 4'h5));
    @(posedge clk); #1;
    in4.data = b; in4.inv = 1; in4.tag = 4'h6;
    sb.push_back(exp4(b, 1'b1, 4'h6));
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (out4.valid !== 1'b1 || {out4.inv, out4.tag, out4.data} !== e) begin
      n_errors++;
      $display("FAIL pair_first: got v=%b %h want v=1 %h", out4.valid, {out4.inv, out4.tag, out4.data}, e);
    end
    @(posedge clk); #1;
    in4.valid = 0; in4.data = 'x;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (out4.valid !== 1'b1 || {out4.inv, out4.tag, out4.data} !== e) begin
      n_errors++;
      $display("FAIL pair_second: got v=%b %h want v=1 %h", out4.valid, {out4.inv, out4.tag, out4.data}, e);
    end
    @(negedge clk);
    n_checks++;
    if (out4.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pair_drain: got out_valid=%b want 0", out4.valid);
    end
  endtask

  task automatic test_nb8();
    logic [255:0] d, r, p;
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = i[7:0];
    p = ref_perm(8, d, 1'b0);
    @(posedge clk); #1;
    in8.valid = 1; in8.data = d; in8.inv = 0; in8.tag = 4'h8; out8.ready = 1;
    @(posedge clk); #1;
    in8.valid = 0; in8.data = 'x;
    @(negedge clk);
    r = out8.data;
    n_checks++;
    if (out8.valid !== 1'b1 || r[255:224] !== 32'h00050e13) begin
      n_errors++;
      $display("FAIL nb8_col0: got v=%b col0=%h want v=1 col0=00050e13", out8.valid, r[255:224]);
    end
    n_checks++;
    if (r !== p) begin
      n_errors++;
      $display("FAIL nb8_fwd: got %h want %h", r, p);
    end
    @(posedge clk); #1;
    in8.valid = 1; in8.data = r; in8.inv = 1; in8.tag = 4'h9;
    @(posedge clk); #1;
    in8.valid = 0; in8.data = 'x;
    @(negedge clk);
    n_checks++;
    if (out8.valid !== 1'b1 || out8.inv !== 1'b1 || out8.data !== d) begin
      n_errors++;
      $display("FAIL nb8_inv: got v=%b inv=%b %h want v=1 inv=1 %h", out8.valid, out8.inv, out8.data, d);
    end
  endtask

  task automatic test_nb6();
    logic [191:0] d, r;
    logic [255:0] p;
    for (int i = 0; i < 24; i++) d[191-8*i -: 8] = i[7:0];
    p = ref_perm(6, {64'b0, d}, 1'b0);
    @(posedge clk); #1;
    in6.valid = 1; in6.data = d; in6.inv = 0; in6.tag = 4'h6; out6.ready = 1;
    @(posedge clk); #1;
    in6.valid = 0; in6.data = 'x;
    @(negedge clk);
    r = out6.data;
    n_checks++;
    if (out6.valid !== 1'b1 || r[191:160] !== 32'h00050a0f) begin
      n_errors++;
      $display("FAIL nb6_col0: got v=%b col0=%h want v=1 col0=00050a0f", out6.valid, r[191:160]);
    end
    n_checks++;
    if (r !== p[191:0]) begin
      n_errors++;
      $display("FAIL nb6_fwd: got %h want %h", r, p[191:0]);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] b1, b2, b3, held;
    logic [132:0] e;
    b1 = rand128(); b2 = rand128(); b3 = rand128();
    @(posedge clk); #1;
    out4.ready = 0;
    in4.valid = 1; in4.data = b1; in4.inv = 0; in4.tag = 4'h1;
    @(negedge clk);
    if (in4.ready === 1'b1) sb.push_back(exp4(b1, 1'b0, 4'h1));
    @(posedge clk); #1;
    in4.data = b2; in4.inv = 1; in4.tag = 4'h2;
    @(negedge clk);
    n_checks++;
    if (in4.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_second_ready: got %b want 1", in4.ready);
    end
    if (in4.ready === 1'b1) sb.push_back(exp4(b2, 1'b1, 4'h2));
    @(posedge clk); #1;
    in4.data = b3; in4.inv = 0; in4.tag = 4'h3;
    @(negedge clk);
    n_checks++;
    if (in4.ready !== 1'b0 || busy4 !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: got in_ready=%b busy=%b want in_ready=0 busy=1", in4.ready, busy4);
    end
    held = out4.data;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (in4.ready !== 1'b0 || out4.valid !== 1'b1 || out4.data !== held) begin
      n_errors++;
      $display("FAIL bp_stable: got rdy=%b v=%b data=%h want rdy=0 v=1 data=%h", in4.ready, out4.valid, out4.data, held);
    end
    @(posedge clk); #1;
    out4.ready = 1;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (in4.ready !== 1'b0 || {out4.inv, out4.tag, out4.data} !== e) begin
      n_errors++;
      $display("FAIL bp_out1: got rdy=%b %h want rdy=0 %h", in4.ready, {out4.inv, out4.tag, out4.data}, e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (in4.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_reready: got in_ready=%b want 1", in4.ready);
    end
    if (in4.ready === 1'b1) sb.push_back(exp4(b3, 1'b0, 4'h3));
    e = sb.pop_front();
    n_checks++;
    if ({out4.inv, out4.tag, out4.data} !== e) begin
      n_errors++;
      $display("FAIL bp_out2: got %h want %h", {out4.inv, out4.tag, out4.data}, e);
    end
    @(posedge clk); #1;
    in4.valid = 0; in4.data = 'x;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL bp_out3: got no pending block want block 3");
    end else begin
      e = sb.pop_front();
      if (out4.valid !== 1'b1 || {out4.inv, out4.tag, out4.data} !== e) begin
        n_errors++;
        $display("FAIL bp_out3: got v=%b %h want v=1 %h", out4.valid, {out4.inv, out4.tag, out4.data}, e);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out4.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: got out_valid=%b want 0", out4.valid);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic [127:0] cur;
    logic cur_inv;
    logic [3:0] cur_tag;
    logic [132:0] e;
    cur = rand128(); cur_inv = 1'($urandom_range(0, 1)); cur_tag = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    while (recv < 64 && cyc < 3000) begin
      in4.valid = (sent < 64) && ((sent < 16) || ($urandom_range(0, 3) != 0));
      in4.data = in4.valid ? cur : 'x;
      in4.inv = cur_inv;
      in4.tag = cur_tag;
      out4.ready = (sent < 16) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (sent < 16) begin
        n_checks++;
        if (in4.ready !== 1'b1) begin
          n_errors++;
          $display("FAIL stream_full_rate: got in_ready=%b want 1 at block %0d", in4.ready, sent);
        end
      end
      if (out4.valid === 1'b1 && out4.ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got output %h want none", out4.data);
        end else begin
          e = sb.pop_front();
          if ({out4.inv, out4.tag, out4.data} !== e) begin
            n_errors++;
            $display("FAIL stream_data: got %h want %h", {out4.inv, out4.tag, out4.data}, e);
          end
        end
        recv++;
      end
      if (in4.valid === 1'b1 && in4.ready === 1'b1) begin
        sb.push_back(exp4(cur, cur_inv, cur_tag));
        sent++;
        cur = rand128(); cur_inv = 1'($urandom_range(0, 1)); cur_tag = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in4.valid = 0; in4.data = 'x; out4.ready = 1;
    n_checks++;
    if (recv != 64 || sent != 64 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL stream_count: got sent=%0d recv=%0d pending=%0d want 64 64 0", sent, recv, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out4.ready = 0;
    in4.valid = 1; in4.data = rand128(); in4.inv = 0; in4.tag = 4'hA;
    @(posedge clk); #1;
    in4.data = rand128(); in4.tag = 4'hB;
    @(posedge clk); #1;
    in4.valid = 0; in4.data = 'x;
    @(negedge clk);
    n_checks++;
    if (in4.ready !== 1'b0 || out4.valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_full: got rdy=%b v=%b want rdy=0 v=1", in4.ready, out4.valid);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out4.valid, busy4, in4.ready, out4.inv, out4.tag} !== 8'b0010_0000 || out4.data !== 128'h0) begin
      n_errors++;
      $display("FAIL rst_async: got v=%b busy=%b rdy=%b inv=%b tag=%h data=%h want 0 0 1 0 0 0",
               out4.valid, busy4, in4.ready, out4.inv, out4.tag, out4.data);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    test_vector(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h7,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, "rst_fresh");
  endtask

  initial begin
    test_reset();
    test_vector(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h3,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, "nb4_fwd");
    test_vector(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'h9,
                128'hd42711aee0bf98f1b8b45de51e415230, "nb4_inv");
    test_mixed_pair();
    test_nb8();
    test_nb6();
    test_back_pressure();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
